// File: rtl/sram_scanout_scheduler.sv
// Raster scan-out scheduler: issues SRAM pixel reads in raster order, pairs each
// returned pixel with its coordinate and writes {x, y, pixel} words to the DAC FIFO.
module sram_scanout_scheduler #(
  parameter int H_TOTAL         = 1056,
  parameter int V_TOTAL         = 628,
  parameter int H_VISIBLE       = 800,
  parameter int V_VISIBLE       = 600,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REQ_INTERVAL    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        request_active,
  output logic [10:0] request_x,
  output logic [10:0] request_y,
  input  logic        request_ready,
  input  logic [15:0] request_data,
  input  logic        fifo_almost_full,
  output logic        fifo_write,
  output logic [37:0] fifo_data,
  output logic        frame_start,
  output logic        unexpected_response
);

  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(REQ_INTERVAL + 1);

  localparam logic [10:0]   H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0]   V_VIS      = 11'(V_VISIBLE);
  localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(REQ_INTERVAL - 1);

  logic [10:0]   sx_q, sx_d, sy_q, sy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [21:0]   tag_q [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic        request_active_q, request_active_d;
  logic [10:0] request_x_q, request_x_d, request_y_q, request_y_d;
  logic        fifo_write_q, fifo_write_d;
  logic [37:0] fifo_data_q, fifo_data_d;
  logic        frame_start_q, frame_start_d;
  logic        unexpected_q, unexpected_d;

  logic full, empty, visible, ready_to_advance;
  logic adv_vis, adv_blank, advance, push, pop;

  always_comb begin
    full             = (count_q == FULL_CNT);
    empty            = (count_q == '0);
    visible          = (sx_q < H_VIS) && (sy_q < V_VIS);
    ready_to_advance = (cnt_q == '0) && enable && !fifo_almost_full;
    adv_vis          = ready_to_advance && visible && !full;
    // Blanking words bypass SRAM; only emitted once every read has returned,
    // so they cannot overtake a pending response or collide with one.
    adv_blank        = ready_to_advance && !visible && empty && !request_ready;
    advance          = adv_vis || adv_blank;
    push             = adv_vis;
    pop              = request_ready && !empty;
  end

  always_comb begin
    sx_d  = sx_q;
    sy_d  = sy_q;
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = CNT_RELOAD;
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? '0 : sy_q + 11'd1;
      end else begin
        sx_d = sx_q + 11'd1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW + 1)'(1);
    else if (pop && !push) count_d = count_q - (AW + 1)'(1);
  end

  always_comb begin
    request_active_d = adv_vis;
    request_x_d      = adv_vis ? sx_q : request_x_q;
    request_y_d      = adv_vis ? sy_q : request_y_q;
    fifo_write_d     = pop || adv_blank;
    fifo_data_d      = fifo_data_q;
    if (pop)            fifo_data_d = {tag_q[rd_ptr_q], request_data};
    else if (adv_blank) fifo_data_d = {sx_q, sy_q, 16'h0000};
    frame_start_d    = fifo_write_d && (fifo_data_d[37:16] == '0);
    unexpected_d     = unexpected_q || (request_ready && empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q             <= '0;
      sy_q             <= '0;
      cnt_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      request_active_q <= 1'b0;
      request_x_q      <= '0;
      request_y_q      <= '0;
      fifo_write_q     <= 1'b0;
      fifo_data_q      <= '0;
      frame_start_q    <= 1'b0;
      unexpected_q     <= 1'b0;
    end else begin
      sx_q             <= sx_d;
      sy_q             <= sy_d;
      cnt_q            <= cnt_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      request_active_q <= request_active_d;
      request_x_q      <= request_x_d;
      request_y_q      <= request_y_d;
      fifo_write_q     <= fifo_write_d;
      fifo_data_q      <= fifo_data_d;
      frame_start_q    <= frame_start_d;
      unexpected_q     <= unexpected_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) tag_q[wr_ptr_q] <= {sx_q, sy_q};
  end

  assign request_active      = request_active_q;
  assign request_x           = request_x_q;
  assign request_y           = request_y_q;
  assign fifo_write          = fifo_write_q;
  assign fifo_data           = fifo_data_q;
  assign frame_start         = frame_start_q;
  assign unexpected_response = unexpected_q;

endmodule

// File: tb/tb_sram_scanout_scheduler.sv
// Bench for sram_scanout_scheduler on a reduced raster; an expected-word queue
// is fed by a raster generator and drained by a monitor on every fifo_write.
module tb_sram_scanout_scheduler;

  localparam int HT = 12;
  localparam int VT = 6;
  localparam int HV = 8;
  localparam int VV = 4;
  localparam int MO = 4;
  localparam int RI = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        request_active;
  logic [10:0] request_x, request_y;
  logic        request_ready = 1'b0;
  logic [15:0] request_data = '0;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_write;
  logic [37:0] fifo_data;
  logic        frame_start;
  logic        unexpected_response;

  always #5 clk = ~clk;

  sram_scanout_scheduler #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
    .MAX_OUTSTANDING(MO), .REQ_INTERVAL(RI)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .request_active(request_active), .request_x(request_x), .request_y(request_y),
    .request_ready(request_ready), .request_data(request_data),
    .fifo_almost_full(fifo_almost_full), .fifo_write(fifo_write), .fifo_data(fifo_data),
    .frame_start(frame_start), .unexpected_response(unexpected_response)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [37:0] exp_word(input int x, input int y);
    logic [10:0] xx, yy;
    xx = 11'(x);
    yy = 11'(y);
    if (x < HV && y < VV) return {xx, yy, xx[7:0], yy[7:0]};
    return {xx, yy, 16'h0000};
  endfunction

  // Expected output stream: raster order restarting at (0,0) on reset.
  logic [37:0] expq[$];
  int gx = 0, gy = 0;
  always @(posedge clk) begin
    if (rst) begin
      expq.delete();
      gx = 0;
      gy = 0;
    end else begin
      while (expq.size() < 16) begin
        expq.push_back(exp_word(gx, gy));
        if (gx == HT - 1) begin
          gx = 0;
          gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
          gx++;
        end
      end
    end
  end

  // Monitor
  int fs_seen = 0;
  int wr_since = 0;
  bit fs_valid = 1'b0;
  logic [37:0] e;
  always @(negedge clk) begin
    if (rst) begin
      wr_since = 0;
      fs_valid = 1'b0;
    end else if (fifo_write) begin
      if (expq.size() == 0) chk("write_with_no_expected", 1, 0);
      else begin
        e = expq.pop_front();
        chk("fifo_data", fifo_data, e);
        chk("frame_start", frame_start, e[37:16] == 22'd0);
      end
      if (frame_start) begin
        if (fs_valid) chk("frame_words", wr_since, HT * VT);
        fs_valid = 1'b1;
        wr_since = 0;
        fs_seen++;
      end
      wr_since++;
    end else if (frame_start) begin
      chk("frame_start_without_write", 1, 0);
    end
  end

  // SRAM model: fixed latency, data = {x[7:0], y[7:0]}, in-order responses.
  typedef struct { int due; logic [15:0] d; } rsp_t;
  rsp_t pend[$];
  rsp_t r;
  int cyc = 0;
  int lat = 3;
  bit inject = 1'b0;
  always @(negedge clk) begin
    cyc++;
    request_ready = 1'b0;
    if (inject) begin
      request_ready = 1'b1;
      request_data  = 16'hBEEF;
      inject = 1'b0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      request_ready = 1'b1;
      request_data  = r.d;
    end
    if (!rst && request_active) begin
      chk("request_visible", (request_x < HV) && (request_y < VV), 1);
      r.due = cyc + lat;
      r.d   = {request_x[7:0], request_y[7:0]};
      pend.push_back(r);
      chk("outstanding_limit", pend.size() <= MO, 1);
    end
  end

  // Called at a negedge; checks outputs one cycle after the reset edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_request_active", request_active, 0);
    chk("rst_request_xy", {request_x, request_y}, 0);
    chk("rst_fifo_write", fifo_write, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_unexpected", unexpected_response, 0);
    #1 rst = 1'b0;
  endtask

  task automatic wait_fs(input int n, input int budget);
    int target;
    target = fs_seen + n;
    while (fs_seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("frame_start_seen", fs_seen >= target, 1);
  endtask

  task automatic wait_req(input int x, input int y, input int budget);
    bit hit;
    hit = 1'b0;
    while (!hit && budget > 0) begin
      @(negedge clk);
      hit = request_active && (request_x == 11'(x)) && (request_y == 11'(y));
      budget--;
    end
    chk("request_seen", hit, 1);
  endtask

  initial begin
    do_reset();

    // Spurious response with nothing outstanding
    @(negedge clk);
    #1 inject = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("spurious_no_write", fifo_write, 0);
    end
    chk("unexpected_set", unexpected_response, 1);
    repeat (4) @(negedge clk);
    chk("unexpected_sticky", unexpected_response, 1);
    @(negedge clk);
    do_reset();

    // Full frames at latency 3, then latency 12
    lat = 3;
    enable = 1'b1;
    wait_fs(2, 2000);
    lat = 12;
    wait_fs(1, 4000);
    lat = 3;

    // Back-pressure mid-line
    wait_req(4, 1, 1000);
    #1 fifo_almost_full = 1'b1;
    repeat (50) begin
      @(negedge clk);
      chk("almost_full_no_request", request_active, 0);
    end
    #1 fifo_almost_full = 1'b0;

    // Enable low mid-line
    wait_req(2, 2, 1000);
    #1 enable = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("disabled_no_request", request_active, 0);
    end
    #1 enable = 1'b1;
    wait_fs(1, 2000);

    // Reset with reads in flight; late responses must be flagged, not written
    lat = 6;
    wait_req(5, 2, 1000);
    enable = 1'b0;
    do_reset();
    repeat (12) begin
      @(negedge clk);
      chk("stale_no_write", fifo_write, 0);
    end
    chk("stale_unexpected", unexpected_response, 1);
    do_reset();
    lat = 3;
    enable = 1'b1;
    wait_fs(1, 500);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_scanout_scheduler.md
Name: sram_scanout_scheduler

Overview:
- Generates the raster of foreground pixel read requests into the SRAM wrapper.
- Pairs each returned pixel with the coordinate that requested it and pushes {x, y, data} words into the DAC pixel FIFO.
- Sits between the SRAM wrapper request/response port and the DAC FIFO write port in the clk80 domain.
- Adds in-order coordinate tracking, FIFO back-pressure and blanking bypass, so blanking coordinates never consume SRAM bandwidth.

Parameters:
- H_TOTAL, 1056, pixels per line including blanking
- V_TOTAL, 628, lines per frame including blanking
- H_VISIBLE, 800, visible pixels per line (x < H_VISIBLE is visible)
- V_VISIBLE, 600, visible lines (y < V_VISIBLE is visible)
- MAX_OUTSTANDING, 4, tag queue depth = maximum SRAM reads in flight (power of 2, 2..16)
- REQ_INTERVAL, 2, minimum clk cycles between successive request_active pulses (>=1)

Ports:
- clk  in  1  single clock (clk80 domain)
- rst  in  1  synchronous, active-high reset
- enable  in  1  allow issuing new scan positions
- request_active  out  1  one-cycle SRAM read request strobe
- request_x  out  11  x of current request, valid with request_active
- request_y  out  11  y of current request, valid with request_active
- request_ready  in  1  SRAM read data valid, one pulse per request, in request order
- request_data  in  16  SRAM pixel data, valid with request_ready
- fifo_almost_full  in  1  DAC FIFO cannot accept bursts; stop advancing
- fifo_write  out  1  DAC FIFO write enable
- fifo_data  out  38  {x[10:0], y[10:0], pixel[15:0]}
- frame_start  out  1  pulse coincident with the fifo_write of (0,0)
- unexpected_response  out  1  sticky: request_ready seen with empty tag queue

Behaviour:
- One clock; reset is synchronous and active-high on rst (clk/rst).
- Reset values: all outputs 0; scan position (0,0); tag queue empty; interval counter 0.
- Scan position (sx, sy):
  - sx wraps to 0 at H_TOTAL-1 and increments sy.
  - sy wraps to 0 at V_TOTAL-1.
  - Arithmetic is 11-bit unsigned; no other wrap is legal.
- Interval counter: reloads to REQ_INTERVAL-1 on each advance and decrements to 0. "ready_to_advance" = counter==0 && enable && !fifo_almost_full.
- Visible position (sx<H_VISIBLE && sy<V_VISIBLE) advances when ready_to_advance && queue not full. Same cycle:
  - register request_active=1 with request_x=sx, request_y=sy (visible next cycle)
  - push {sx,sy} into tag queue
  - step the scan position.
- Blanking position advances only when ready_to_advance && queue empty && !request_ready. No SRAM request. Next cycle: fifo_write=1, fifo_data={sx,sy,16'h0000}. This preserves output order without a skid buffer.
- Response: on request_ready with queue non-empty, pop head and register fifo_write=1, fifo_data={head_x,head_y,request_data}. Latency is exactly 1 cycle.
- Push and pop in the same cycle are legal; occupancy is unchanged. Full queue with a simultaneous pop still blocks the push that cycle (push gated on pre-pop full).
- request_ready with empty queue: data dropped, no fifo_write, unexpected_response set to 1 until rst.
- At most one fifo_write per cycle. The response and blank paths are mutually exclusive by the blank rule above.
- frame_start=1 exactly on the cycle fifo_write carries x=0,y=0.
- enable low: no new advances. Outstanding responses still drain to the FIFO. Scan resumes from the held position when enable returns.
- fifo_almost_full only stalls issue. In-flight responses are always written; the FIFO almost-full threshold must leave ≥ MAX_OUTSTANDING+1 slots.
- Reset mid-operation: queue and scan cleared immediately. Late responses from pre-reset requests hit the empty-queue rule.

Test Plan:
- Fixed-latency SRAM model (3 cycles, data = {x[7:0],y[7:0]}), enable=1, one full frame → exactly 1056*628 fifo_writes in raster order. Every visible word's pixel equals its own {x,y} encoding. Every blanking word has pixel 0. One frame_start.
- SRAM latency 12 cycles, MAX_OUTSTANDING=4 → never more than 4 request_active without request_ready. Order and pairing remain correct.
- fifo_almost_full held high for 50 cycles mid-line at x=400 → no request_active after the assertion cycle. Pending ≤4 responses still written. Scan resumes at the next x with no skip or duplicate.
- Visible→blanking boundary (x=799→800) with 3 reads in flight → x=800 word written only after the (799,y) word. No request_active for x=800.
- Spurious request_ready pulse after reset with no requests → no fifo_write; unexpected_response=1 and stays 1 until next rst.
- rst asserted for 1 cycle at (500,300) with 2 reads in flight → next output word is (0,0) with frame_start. Outputs are 0 in the reset cycle+1.
